// File: rtl/xbee_frame_parser.sv
// xbee_frame_parser: turns the XBee receiver byte stream into framed commands.
// Frame format: SOF, length (1..MAX_LEN), payload bytes, checksum, where a
// good frame has (sum(payload) + checksum) mod 256 == 8'hFF. The payload is
// written into an internal buffer as it arrives and is readable combinationally.
//
// Handshake: rx_ready is a level from the receiver that rises once per byte and
// stays high until the next start bit; one byte is consumed on its rising edge
// only. frame_valid / frame_err are single-cycle pulses with no back-pressure;
// the consumer must read the buffer after frame_valid and before the next SOF.
module xbee_frame_parser #(
  parameter int          MAX_LEN        = 16,
  parameter logic [7:0]  SOF_BYTE       = 8'h7E,
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  localparam int         AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [7:0]    frame_len,
  output logic          frame_valid,
  output logic          frame_err,
  output logic [1:0]    err_code,
  output logic          busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] LEN     = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] CSUM    = 2'd3;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          rx_ready_q;
  logic [7:0]    len_q, len_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    frame_len_q, frame_len_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          frame_valid_q, frame_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          wr_en;
  logic          byte_stb;
  logic          timeout;
  logic [7:0]    csum_final;

  // Payload buffer, sized to a power of two so every rd_addr value is in range.
  logic [7:0] mem [0:(1<<AW)-1];

  assign byte_stb   = rx_ready & ~rx_ready_q;
  assign timeout    = (timer_q == TMO_LAST);
  assign csum_final = csum_q + rx_data;

  // Next-state logic: frame FSM, checksum/count accumulation and inter-byte timer.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    count_d       = count_q;
    csum_d        = csum_q;
    timer_d       = timer_q;
    frame_len_d   = frame_len_q;
    err_code_d    = err_code_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    wr_en         = 1'b0;

    if (state_q != HUNT) begin
      timer_d = byte_stb ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      HUNT: begin
        timer_d = '0;
        if (byte_stb && rx_data == SOF_BYTE) begin
          csum_d  = '0;
          count_d = '0;
          state_d = LEN;
        end
      end
      LEN: begin
        // SOF_BYTE here is just a length value; there is no escaping.
        if (byte_stb) begin
          if (rx_data != 8'd0 && rx_data <= MAX_LEN_B) begin
            len_d   = rx_data;
            state_d = PAYLOAD;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = HUNT;
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TMO;
          state_d     = HUNT;
        end
      end
      PAYLOAD: begin
        if (byte_stb) begin
          wr_en   = 1'b1;
          csum_d  = csum_q + rx_data;
          count_d = count_q + 8'd1;
          if (count_d == len_q) begin
            state_d = CSUM;
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TMO;
          state_d     = HUNT;
        end
      end
      CSUM: begin
        if (byte_stb) begin
          if (csum_final == 8'hFF) begin
            frame_len_d   = len_q;
            frame_valid_d = 1'b1;
            err_code_d    = ERR_NONE;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
          state_d = HUNT;
        end else if (timeout) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TMO;
          state_d     = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State registers; rx_ready_q resets high so an idle-high receiver gives no strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      rx_ready_q    <= 1'b1;
      len_q         <= '0;
      count_q       <= '0;
      csum_q        <= '0;
      timer_q       <= '0;
      frame_len_q   <= '0;
      err_code_q    <= ERR_NONE;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_ready_q    <= rx_ready;
      len_q         <= len_d;
      count_q       <= count_d;
      csum_q        <= csum_d;
      timer_q       <= timer_d;
      frame_len_q   <= frame_len_d;
      err_code_q    <= err_code_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Payload write in place; contents are not reset and an aborted frame leaves debris.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[AW-1:0]] <= rx_data;
    end
  end

  assign rd_data     = mem[rd_addr];
  assign frame_len   = frame_len_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != HUNT);

endmodule

// File: tb/tb_xbee_frame_parser.sv
// Testbench for xbee_frame_parser: byte-level driver, event scoreboard, per-scenario tasks.
module tb_xbee_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 100;

  // Clock / reset
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] frame_len;
  logic       frame_valid;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  xbee_frame_parser #(
    .MAX_LEN(MAX_LEN),
    .SOF_BYTE(8'h7E),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .frame_len(frame_len),
    .frame_valid(frame_valid),
    .frame_err(frame_err),
    .err_code(err_code),
    .busy(busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard entry: {frame_valid, frame_err, err_code, frame_len}
  logic [11:0] exp_q[$];
  logic [7:0]  model_len;
  logic [7:0]  pl [0:15];

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int lo, input int hi);
    rx_ready = 1'b0;
    tick(lo);
    rx_data  = d;
    rx_ready = 1'b1;
    tick(hi);
  endtask

  // Sends SOF, len, pl[0..len-1], correct checksum; expects one good frame.
  task automatic send_frame(input logic [7:0] len, input int lo, input int hi);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < int'(len); i++) sum = sum + pl[i];
    model_len = len;
    exp_q.push_back({1'b1, 1'b0, 2'd0, len});
    send_byte(8'h7E, lo, hi);
    send_byte(len, lo, hi);
    for (int i = 0; i < int'(len); i++) send_byte(pl[i], lo, hi);
    send_byte(8'hFF - sum, lo, hi);
  endtask

  task automatic expect_err(input logic [1:0] code);
    exp_q.push_back({1'b0, 1'b1, code, model_len});
  endtask

  // Scoreboard: every output pulse is popped and compared against the queue.
  always @(negedge clk) begin
    logic [11:0] got;
    logic [11:0] e;
    if (frame_valid || frame_err) begin
      got = {frame_valid, frame_err, err_code, frame_len};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse got=%h required=none t=%0t", got, $time);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL pulse_event got=%h required=%h t=%0t", got, e, $time);
        end
      end
    end
  end

  task automatic test_reset;
    reset    = 1'b1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    rd_addr  = '0;
    model_len = 8'h00;
    tick(3);
    n_cmp++;
    if ({busy, frame_valid, frame_err, err_code, frame_len} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b required=0", {busy, frame_valid, frame_err, err_code, frame_len});
    end
    reset = 1'b0;
    tick(2);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy got=%b required=0", busy);
    end
  endtask

  task automatic test_good_frame;
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    send_frame(8'd3, 2, 2);
    tick(2);
    n_cmp++;
    if (frame_len !== 8'd3 || err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL good_len_code got=%h/%0d required=03/0", frame_len, err_code);
    end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 4'(i);
      #1;
      n_cmp++;
      if (rd_data !== pl[i]) begin
        n_fail++;
        $display("FAIL good_payload[%0d] got=%h required=%h", i, rd_data, pl[i]);
      end
    end
  endtask

  task automatic test_bad_checksum;
    expect_err(2'd2);
    send_byte(8'h7E, 2, 2);
    send_byte(8'h02, 2, 2);
    send_byte(8'h10, 2, 2);
    send_byte(8'h20, 2, 2);
    send_byte(8'h00, 2, 2);
    tick(2);
    n_cmp++;
    if (frame_len !== 8'd3 || err_code !== 2'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_csum_state got=%h/%0d/%b required=03/2/0", frame_len, err_code, busy);
    end
  endtask

  task automatic test_bad_length;
    expect_err(2'd1);
    send_byte(8'h7E, 2, 2);
    send_byte(8'h00, 2, 2);
    expect_err(2'd1);
    send_byte(8'h7E, 2, 2);
    send_byte(8'h11, 2, 2);
    expect_err(2'd1);
    send_byte(8'h7E, 2, 2);
    send_byte(8'h7E, 2, 2);
    tick(2);
    n_cmp++;
    if (err_code !== 2'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_len_state got=%0d/%b required=1/0", err_code, busy);
    end
    // Length 1 frame whose payload equals SOF.
    pl[0] = 8'h7E;
    send_frame(8'd1, 2, 2);
    tick(2);
    rd_addr = 4'd0;
    #1;
    n_cmp++;
    if (frame_len !== 8'd1 || err_code !== 2'd0 || rd_data !== 8'h7E) begin
      n_fail++;
      $display("FAIL len1_frame got=%h/%0d/%h required=01/0/7e", frame_len, err_code, rd_data);
    end
  endtask

  task automatic test_max_len;
    for (int i = 0; i < MAX_LEN; i++) pl[i] = 8'($urandom_range(0, 255));
    send_frame(8'(MAX_LEN), 2, 2);
    tick(2);
    n_cmp++;
    if (frame_len !== 8'(MAX_LEN)) begin
      n_fail++;
      $display("FAIL max_len got=%0d required=%0d", frame_len, MAX_LEN);
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      rd_addr = 4'(i);
      #1;
      n_cmp++;
      if (rd_data !== pl[i]) begin
        n_fail++;
        $display("FAIL max_payload[%0d] got=%h required=%h", i, rd_data, pl[i]);
      end
    end
  endtask

  task automatic test_timeout;
    int hit;
    hit = -1;
    expect_err(2'd3);
    send_byte(8'h7E, 2, 2);
    send_byte(8'h02, 2, 2);
    send_byte(8'hAA, 2, 1);
    for (int k = 1; k <= 2 * TMO && hit < 0; k++) begin
      tick(1);
      if (frame_err) hit = k;
    end
    n_cmp++;
    if (hit != TMO) begin
      n_fail++;
      $display("FAIL timeout_latency got=%0d required=%0d", hit, TMO);
    end
    n_cmp++;
    if (busy !== 1'b0 || err_code !== 2'd3) begin
      n_fail++;
      $display("FAIL timeout_state got=%b/%0d required=0/3", busy, err_code);
    end
    tick(2);
  endtask

  // Garbage held high for 5000 cycles; in-frame bytes spaced exactly TMO cycles
  // apart so each strobe lands on the cycle the timeout would otherwise fire.
  task automatic test_long_hold;
    send_byte(8'h55, 2, 5000);
    send_byte(8'hFF, 2, 5000);
    pl[0] = 8'h5A; pl[1] = 8'hC3; pl[2] = 8'h0F;
    send_frame(8'd3, 20, 80);
    n_cmp++;
    if (frame_len !== 8'd3 || err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL long_hold_frame got=%h/%0d required=03/0", frame_len, err_code);
    end
    rd_addr = 4'd1;
    #1;
    n_cmp++;
    if (rd_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL long_hold_payload got=%h required=c3", rd_data);
    end
  endtask

  task automatic test_reset_mid;
    send_byte(8'h7E, 2, 2);
    send_byte(8'h05, 2, 2);
    send_byte(8'h11, 2, 2);
    send_byte(8'h22, 2, 2);
    #3;
    reset = 1'b1;
    #1;
    model_len = 8'h00;
    n_cmp++;
    if (busy !== 1'b0 || frame_valid !== 1'b0 || frame_err !== 1'b0 || frame_len !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%b%b%b/%h required=000/00", busy, frame_valid, frame_err, frame_len);
    end
    tick(2);
    reset = 1'b0;
    tick(3);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle got=%b required=0", busy);
    end
    pl[0] = 8'h33; pl[1] = 8'h44;
    send_frame(8'd2, 2, 2);
    tick(2);
    n_cmp++;
    if (frame_len !== 8'd2) begin
      n_fail++;
      $display("FAIL reset_mid_next got=%0d required=2", frame_len);
    end
  endtask

  task automatic test_back_to_back;
    pl[0] = 8'h80; pl[1] = 8'h90;
    send_frame(8'd2, 1, 1);
    pl[0] = 8'hFE;
    send_frame(8'd1, 1, 1);
    tick(2);
    rd_addr = 4'd0;
    #1;
    n_cmp++;
    if (frame_len !== 8'd1 || rd_data !== 8'hFE) begin
      n_fail++;
      $display("FAIL back_to_back got=%h/%h required=01/fe", frame_len, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_max_len();
    test_timeout();
    test_long_hold();
    test_reset_mid();
    test_back_to_back();
    tick(5);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses got=%0d pending required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
